// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status control for fifo_sync_flags; count is the sole source of full/empty.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  output logic                         wr_en_o,
  output logic                         rd_en_o,
  output logic [ptr_width(DEPTH)-1:0]  wr_ptr_o,
  output logic [ptr_width(DEPTH)-1:0]  rd_ptr_o,
  output logic [cnt_width(DEPTH)-1:0]  count_o,
  output logic                         full_o,
  output logic                         pndng_o,
  output logic                         almost_full_o,
  output logic                         almost_empty_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, underflow_q;
  logic          push_ok, pop_ok;

  assign full_o         = (count_q == DEPTH_C);
  assign pndng_o        = (count_q != '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);

  // A pop frees the slot on the same edge, so a full FIFO may still accept a push.
  assign pop_ok  = pop_i & pndng_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= push_i & ~push_ok;
      underflow_q <= pop_i & ~pop_ok;
    end
  end

  assign wr_en_o     = push_ok;
  assign rd_en_o     = pop_ok;
  assign wr_ptr_o    = wr_ptr_q;
  assign rd_ptr_o    = rd_ptr_q;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, programmable thresholds, error pulses and STD/FWFT read modes.
module fifo_sync_flags
  import fifo_pkg::*;
#(
  parameter int unsigned BITS     = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned FWFT     = FIFO_MODE_STD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BITS-1:0]             din,
  input  logic                        push,
  input  logic                        pop,
  output logic [BITS-1:0]             dout,
  output logic                        full,
  output logic                        pndng,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PW = ptr_width(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $fatal(1, "fifo_sync_flags: DEPTH must be a power of two and >= 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $fatal(1, "fifo_sync_flags: require AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            wr_en, rd_en;

  fifo_ptr_ctrl #(
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .pop_i          (pop),
    .wr_en_o        (wr_en),
    .rd_en_o        (rd_en),
    .wr_ptr_o       (wr_ptr),
    .rd_ptr_o       (rd_ptr),
    .count_o        (count),
    .full_o         (full),
    .pndng_o        (pndng),
    .almost_full_o  (almost_full),
    .almost_empty_o (almost_empty),
    .overflow_o     (overflow),
    .underflow_o    (underflow)
  );

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= din;
  end

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    // Gated to zero when empty so reset shows dout=0 in this mode as well.
    assign dout = pndng ? mem_q[rd_ptr] : '0;
  end else begin : g_std
    logic [BITS-1:0] dout_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)       dout_q <= '0;
      else if (rd_en) dout_q <= mem_q[rd_ptr];
    end
    assign dout = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Randomised scoreboard bench for fifo_sync_flags, running STD and FWFT instances on the same stimulus.
module tb_fifo_sync_flags;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 7;
  localparam int unsigned AE    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       push = 1'b0;
  logic       pop = 1'b0;

  logic [7:0] s_dout, f_dout;
  logic       s_full, s_pndng, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_pndng, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_count, f_count;

  fifo_sync_flags #(.BITS(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut_std (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .dout(s_dout),
    .full(s_full), .pndng(s_pndng), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_count), .overflow(s_ovf), .underflow(s_unf));

  fifo_sync_flags #(.BITS(8), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut_fw (
    .clk(clk), .rst(rst), .din(din), .push(push), .pop(pop), .dout(f_dout),
    .full(f_full), .pndng(f_pndng), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_count), .overflow(f_ovf), .underflow(f_unf));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: contents as a queue; reads as a queue of words owed to the STD output.
  logic [7:0] model_q[$];
  logic [7:0] std_rd_q[$];
  logic [7:0] std_hold = '0;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge rst) begin
    model_q.delete();
    std_rd_q.delete();
    std_hold = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      int  sz;
      bit  take, give;
      sz   = model_q.size();
      take = pop && (sz > 0);
      give = push && ((sz < DEPTH) || take);
      if (take) std_rd_q.push_back(model_q.pop_front());
      if (give) model_q.push_back(din);
      exp_ovf = push && !give;
      exp_unf = pop && !take;
    end
  end

  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    if (std_rd_q.size() > 0) std_hold = std_rd_q.pop_front();
    chk("count_std", int'(s_count), sz);
    chk("count_fw", int'(f_count), sz);
    chk("full", int'(s_full), int'(sz == DEPTH));
    chk("pndng", int'(s_pndng), int'(sz != 0));
    chk("almost_full", int'(s_af), int'(sz >= AF));
    chk("almost_empty", int'(s_ae), int'(sz <= AE));
    chk("overflow", int'(s_ovf), int'(exp_ovf));
    chk("underflow", int'(s_unf), int'(exp_unf));
    chk("fw_flags", {f_full, f_pndng, f_af, f_ae, f_ovf, f_unf},
        {s_full, s_pndng, s_af, s_ae, s_ovf, s_unf});
    chk("dout_std", int'(s_dout), int'(std_hold));
    if (sz != 0) chk("dout_fwft_head", int'(f_dout), int'(model_q[0]));
  end

  task automatic cyc(input logic ps, input logic pp, input logic [7:0] d);
    @(negedge clk);
    push = ps;
    pop  = pp;
    din  = d;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 chk("reset_dout_std", int'(s_dout), 0);
    chk("reset_dout_fw", int'(f_dout), 0);
    chk("reset_count", int'(s_count), 0);
    rst = 1'b1;
    repeat (10) cyc(1'b0, 1'b0, 8'h00);

    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 8'(i));
    cyc(1'b1, 1'b0, 8'hAA);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'h30 + i));
    cyc(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 8'h33);
    cyc(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, 8'($urandom));
      cyc(1'b0, 1'b1, 8'h00);
    end

    for (int ph = 0; ph < 12; ph++) begin
      int unsigned pp_push;
      pp_push = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 20 : 50);
      for (int i = 0; i < 40; i++)
        cyc($urandom_range(0, 99) < pp_push, $urandom_range(0, 99) < (100 - pp_push),
            8'($urandom));
    end

    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h60 + i));
    cyc(1'b0, 1'b0, 8'h00);
    #2 rst = 1'b0;
    #1 chk("async_count", int'(s_count), 0);
    chk("async_dout_std", int'(s_dout), 0);
    chk("async_dout_fw", int'(f_dout), 0);
    #1 rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h77);
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1 chk("post_reset_77", int'(s_dout), 8'h77);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
